fp_round_pipe: RTL and testbench
================================

# fp_round_pipe

Parametrised, pipelined rounding stage for the floating-point add/sub datapath. It takes a normalised, extended-precision mantissa with guard/round/sticky bits, exponent and sign, and produces a rounded IEEE-style result. It supports four selectable rounding modes, handles mantissa carry into the exponent, and flags overflow and inexact results. It sits between the normaliser and the result packer, behind a valid/ready handshake, and replaces the fixed round-half-up combinational rounder.

## Interface
Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- GRS_W, 4, extra low-order rounding bits below the fraction LSB; minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  biased exponent.
- in_man  in  MAN_W+GRS_W+1  bit layout:
  - [MAN_W+GRS_W]: hidden bit.
  - [MAN_W+GRS_W-1:GRS_W]: fraction.
  - [GRS_W-1]: guard.
  - [GRS_W-2:0]: sticky field.
- in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  rounded exponent.
- out_frac  out  MAN_W  rounded fraction.
- out_inexact  out  1  at least one discarded bit was nonzero.
- out_overflow  out  1  rounding carried the exponent to all-ones.

## Operation
- Field definitions:
  - G = guard bit.
  - S = OR of the sticky field.
  - L = fraction LSB.
  - any = G|S.
- Increment decision (inc):
  - RNE: G & (S | L).
  - RTZ: 0.
  - RUP: ~sign & any.
  - RDN: sign & any.
- Special-value passthrough: if in_exp is all-ones (inf/NaN), set inc=0 and pass exp, fraction and sign unchanged. In this case inexact=0 and overflow=0.
- Result: {out_exp, out_frac} = {in_exp, fraction} + inc, as one (EXP_W+MAN_W)-bit add.
  - A fraction carry increments the exponent.
  - A subnormal (exp 0) carrying out becomes exp 1, frac 0.
  - The hidden bit is not used in the arithmetic and is not output.
- Overflow: in_exp not all-ones and the result exponent is all-ones. Then out_frac=0 (infinity with the input sign) and out_overflow=1.
- out_inexact = any, except in passthrough.
- Pipeline has two stages, each with a valid bit:
  - S1 registers sign, exp, fraction, inc, inexact and the passthrough flag.
  - S2 registers the final add result and flags.
- Stall rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S1 advances into S2.
  - in_ready = ~s1_valid | ~s2_valid | out_ready.
  - The design is stall-correct: no beat is lost, duplicated or reordered.

## Timing
- Latency: a beat accepted in cycle N (in_valid & in_ready) appears with out_valid=1 in cycle N+2 when unstalled.
- Throughput is one beat per cycle with out_ready held high.
- Output hold under backpressure:
  - While out_valid=1 and out_ready=0, all out_* stay stable.
  - At most 2 beats are held internally; in_ready falls only when both stages are full and out_ready=0.
- Simultaneous accept and drain: a beat entering S1 in the same cycle S2 drains is accepted; no bubble is inserted.
- Reset (asynchronous, any time, including mid-flight):
  - Immediately clears s1_valid, s2_valid, out_valid, out_sign, out_exp, out_frac, out_inexact and out_overflow to 0. In-flight beats are discarded.
  - in_ready reads 1 while rst=1 and after release.
  - The first beat can be accepted on the first edge after rst deasserts.
- out_ready is ignored while out_valid=0.

## Test plan
Defaults: EXP_W=8, MAN_W=23, GRS_W=4; sign=0 unless stated.
- RNE ties:
  - exp=0x80, man=0x8000008 → exp 0x80, frac 0x000000, inexact=1 (tie to even, no increment).
  - man=0x8000018 → frac 0x000002.
- Mode sweep on man=0x8000014 (G=0, S=1):
  - RNE → frac 0x000001.
  - RTZ → 0x000001.
  - RUP sign0 → 0x000002.
  - RDN sign0 → 0x000001.
  - RDN sign1 → 0x000002.
  - All cases: inexact=1.
- Carry into exponent: exp=0x7F, man=0xFFFFFF8, RNE → exp 0x80, frac 0x000000, overflow=0.
- Overflow and passthrough:
  - exp=0xFE, man=0xFFFFFFF, RNE → exp 0xFF, frac 0, overflow=1, inexact=1.
  - Same input with RTZ → exp 0xFE, frac 0x7FFFFF, overflow=0.
  - exp=0xFF, frac 0x400000 (NaN) → unchanged, both flags 0.
- Backpressure: offer 5 back-to-back beats with out_ready=0 for cycles 0–5 → exactly 2 beats accepted, in_ready=0 from the cycle both stages fill, outputs stable. Then raise out_ready → all 5 beats emerge in order with correct values, no gaps after the pipeline refills.
- Reset mid-flight: assert rst asynchronously (between edges) with 2 beats in flight → out_valid drops at once, all outputs 0. After release, one new beat is emitted 2 cycles after acceptance; no stale beats appear.

Source files
------------

// File: rtl/fp_round_pipe.sv
// Two-stage pipelined IEEE-style rounder with four rounding modes and a valid/ready handshake.
// S1 captures the operand and the increment decision; S2 holds the rounded result and its flags.
module fp_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRS_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+GRS_W:0]   in_man,
  input  logic [1:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_W-1:0]       out_exp,
  output logic [MAN_W-1:0]       out_frac,
  output logic                   out_inexact,
  output logic                   out_overflow
);

  localparam int SUM_W = EXP_W + MAN_W;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  // Handshake
  logic s1_load;
  logic s2_load;

  // Stage 1 registers
  logic             s1_valid_q,   s1_valid_d;
  logic             s1_sign_q,    s1_sign_d;
  logic [EXP_W-1:0] s1_exp_q,     s1_exp_d;
  logic [MAN_W-1:0] s1_frac_q,    s1_frac_d;
  logic             s1_inc_q,     s1_inc_d;
  logic             s1_inexact_q, s1_inexact_d;
  logic             s1_pass_q,    s1_pass_d;

  // Stage 2 registers
  logic             s2_valid_q,   s2_valid_d;
  logic             s2_sign_q,    s2_sign_d;
  logic [EXP_W-1:0] s2_exp_q,     s2_exp_d;
  logic [MAN_W-1:0] s2_frac_q,    s2_frac_d;
  logic             s2_inexact_q, s2_inexact_d;
  logic             s2_overflow_q, s2_overflow_d;

  // Stage 1 combinational
  logic guard_bit;
  logic sticky_bit;
  logic lsb_bit;
  logic any_bit;
  logic pass_now;
  logic inc_now;
  rm_e  rm;

  // The hidden bit plays no part in rounding.
  logic unused_hidden;
  assign unused_hidden = in_man[MAN_W+GRS_W];

  // Stage 2 combinational
  logic [SUM_W-1:0] sum;
  logic [EXP_W-1:0] sum_exp;
  logic             sum_ovf;

  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load;

  always_comb begin
    rm         = rm_e'(in_rm);
    guard_bit  = in_man[GRS_W-1];
    sticky_bit = |in_man[GRS_W-2:0];
    lsb_bit    = in_man[GRS_W];
    any_bit    = guard_bit | sticky_bit;
    pass_now   = &in_exp;
    inc_now    = 1'b0;
    case (rm)
      RM_RNE:  inc_now = guard_bit & (sticky_bit | lsb_bit);
      RM_RTZ:  inc_now = 1'b0;
      RM_RUP:  inc_now = ~in_sign & any_bit;
      RM_RDN:  inc_now = in_sign & any_bit;
      default: inc_now = 1'b0;
    endcase
    // Inf/NaN travel through untouched and never raise flags.
    if (pass_now) inc_now = 1'b0;
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_frac_d    = s1_frac_q;
    s1_inc_d     = s1_inc_q;
    s1_inexact_d = s1_inexact_q;
    s1_pass_d    = s1_pass_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d    = in_sign;
        s1_exp_d     = in_exp;
        s1_frac_d    = in_man[MAN_W+GRS_W-1:GRS_W];
        s1_inc_d     = inc_now;
        s1_inexact_d = any_bit & ~pass_now;
        s1_pass_d    = pass_now;
      end
    end
  end

  // One wide add lets a fraction carry ripple naturally into the exponent.
  always_comb begin
    sum     = {s1_exp_q, s1_frac_q} + {{(SUM_W-1){1'b0}}, s1_inc_q};
    sum_exp = sum[SUM_W-1:MAN_W];
    sum_ovf = ~s1_pass_q & (&sum_exp);
  end

  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_sign_d     = s2_sign_q;
    s2_exp_d      = s2_exp_q;
    s2_frac_d     = s2_frac_q;
    s2_inexact_d  = s2_inexact_q;
    s2_overflow_d = s2_overflow_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d     = s1_sign_q;
        s2_exp_d      = sum_exp;
        s2_frac_d     = sum_ovf ? '0 : sum[MAN_W-1:0];
        s2_inexact_d  = s1_inexact_q;
        s2_overflow_d = sum_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_frac_q     <= '0;
      s1_inc_q      <= 1'b0;
      s1_inexact_q  <= 1'b0;
      s1_pass_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_frac_q     <= '0;
      s2_inexact_q  <= 1'b0;
      s2_overflow_q <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= s1_exp_d;
      s1_frac_q     <= s1_frac_d;
      s1_inc_q      <= s1_inc_d;
      s1_inexact_q  <= s1_inexact_d;
      s1_pass_q     <= s1_pass_d;
      s2_valid_q    <= s2_valid_d;
      s2_sign_q     <= s2_sign_d;
      s2_exp_q      <= s2_exp_d;
      s2_frac_q     <= s2_frac_d;
      s2_inexact_q  <= s2_inexact_d;
      s2_overflow_q <= s2_overflow_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_sign     = s2_sign_q;
  assign out_exp      = s2_exp_q;
  assign out_frac     = s2_frac_q;
  assign out_inexact  = s2_inexact_q;
  assign out_overflow = s2_overflow_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed rounding vectors, backpressure, async reset mid-flight,
// then random traffic scored against an arithmetic reference model.
module tb_fp_round_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int GRS_W = 4;
  localparam int MW    = MAN_W + GRS_W + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sign = 1'b0;
  logic [EXP_W-1:0] in_exp = '0;
  logic [MW-1:0]    in_man = '0;
  logic [1:0]       in_rm = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_frac;
  logic             out_inexact;
  logic             out_overflow;

  fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRS_W(GRS_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
    logic             inx;
    logic             ovf;
    int               cyc;
  } beat_t;

  typedef struct {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]    man;
    logic [1:0]       rm;
    logic [EXP_W-1:0] xexp;
    logic [MAN_W-1:0] xfrac;
    logic             xinx;
    logic             xovf;
  } dvec_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    drained = 0;
  bit    last_acc = 0;
  bit    dir_en = 0;
  bit    lat_chk = 0;
  bit    prev_stall = 0;
  logic [EXP_W+MAN_W+2:0] held = '0;
  beat_t dir_b;
  beat_t q[$];
  dvec_t dv[12];

  task automatic check_eq(input string tag, input longint unsigned obs, input longint unsigned expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: treat the discarded bits as a fraction of one ULP and round by value.
  function automatic beat_t model(input logic sg, input logic [EXP_W-1:0] e,
                                  input logic [MW-1:0] m, input logic [1:0] rm);
    beat_t r;
    longint unsigned ulp  = 64'd1 << GRS_W;
    longint unsigned half = ulp / 2;
    longint unsigned frac = (64'(m) / ulp) % (64'd1 << MAN_W);
    longint unsigned rem  = 64'(m) % ulp;
    longint unsigned emax = (64'd1 << EXP_W) - 1;
    longint unsigned v;
    bit up;
    r.sign = sg;
    r.cyc  = 0;
    if (64'(e) == emax) begin
      r.exp = e; r.frac = MAN_W'(frac); r.inx = 0; r.ovf = 0;
      return r;
    end
    case (rm)
      2'd0:    up = (rem > half) || (rem == half && (frac % 2) == 1);
      2'd1:    up = 0;
      2'd2:    up = !sg && rem != 0;
      default: up = sg && rem != 0;
    endcase
    v = 64'(e) * (64'd1 << MAN_W) + frac + 64'(up);
    r.exp  = EXP_W'(v >> MAN_W);
    r.frac = MAN_W'(v % (64'd1 << MAN_W));
    r.inx  = rem != 0;
    r.ovf  = 64'(r.exp) == emax;
    if (r.ovf) r.frac = '0;
    return r;
  endfunction

  // One cycle: sample after inputs settle, score handshakes, advance to the next falling edge.
  task automatic tick();
    beat_t b;
    #1;
    if (prev_stall) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", {out_sign, out_exp, out_frac, out_inexact, out_overflow}, held);
    end
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      b = dir_en ? dir_b : model(in_sign, in_exp, in_man, in_rm);
      b.cyc = cyc;
      q.push_back(b);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) check_eq("spurious_out", 1, 0);
      else begin
        b = q.pop_front();
        check_eq("sign", out_sign, b.sign);
        check_eq("exp", out_exp, b.exp);
        check_eq("frac", out_frac, b.frac);
        check_eq("inexact", out_inexact, b.inx);
        check_eq("overflow", out_overflow, b.ovf);
        if (lat_chk) check_eq("latency", cyc - b.cyc, 2);
        drained++;
      end
    end
    prev_stall = out_valid && !out_ready;
    held = {out_sign, out_exp, out_frac, out_inexact, out_overflow};
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic sg, input logic [EXP_W-1:0] e, input logic [MW-1:0] m,
                      input logic [1:0] rm);
    int n;
    in_valid = 1; in_sign = sg; in_exp = e; in_man = m; in_rm = rm;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) check_eq("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check_eq("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [EXP_W-1:0] bp_e[5];
    logic [MW-1:0]    bp_m[5];
    int k;
    int n;

    dv[0]  = '{1'b0, 8'h80, 28'h8000008, 2'd0, 8'h80, 23'h000000, 1'b1, 1'b0};
    dv[1]  = '{1'b0, 8'h80, 28'h8000018, 2'd0, 8'h80, 23'h000002, 1'b1, 1'b0};
    dv[2]  = '{1'b0, 8'h80, 28'h8000014, 2'd0, 8'h80, 23'h000001, 1'b1, 1'b0};
    dv[3]  = '{1'b0, 8'h80, 28'h8000014, 2'd1, 8'h80, 23'h000001, 1'b1, 1'b0};
    dv[4]  = '{1'b0, 8'h80, 28'h8000014, 2'd2, 8'h80, 23'h000002, 1'b1, 1'b0};
    dv[5]  = '{1'b0, 8'h80, 28'h8000014, 2'd3, 8'h80, 23'h000001, 1'b1, 1'b0};
    dv[6]  = '{1'b1, 8'h80, 28'h8000014, 2'd3, 8'h80, 23'h000002, 1'b1, 1'b0};
    dv[7]  = '{1'b0, 8'h7F, 28'hFFFFFF8, 2'd0, 8'h80, 23'h000000, 1'b1, 1'b0};
    dv[8]  = '{1'b0, 8'hFE, 28'hFFFFFFF, 2'd0, 8'hFF, 23'h000000, 1'b1, 1'b1};
    dv[9]  = '{1'b0, 8'hFE, 28'hFFFFFFF, 2'd1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0};
    dv[10] = '{1'b0, 8'hFF, 28'hC000000, 2'd0, 8'hFF, 23'h400000, 1'b0, 1'b0};
    dv[11] = '{1'b0, 8'h00, 28'h7FFFFF8, 2'd0, 8'h01, 23'h000000, 1'b1, 1'b0};

    // Reset state
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_outputs", {out_sign, out_exp, out_frac, out_inexact, out_overflow}, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    // Directed rounding vectors, unstalled
    out_ready = 1; dir_en = 1; lat_chk = 1;
    for (int i = 0; i < 12; i++) begin
      dir_b = '{dv[i].sign, dv[i].xexp, dv[i].xfrac, dv[i].xinx, dv[i].xovf, 0};
      send(dv[i].sign, dv[i].exp, dv[i].man, dv[i].rm);
    end
    drain(10);
    dir_en = 0; lat_chk = 0;

    // Backpressure: 5 beats offered, only 2 fit while out_ready stays low
    for (int i = 0; i < 5; i++) begin
      bp_e[i] = EXP_W'($urandom_range(1, 254));
      bp_m[i] = MW'($urandom);
    end
    out_ready = 0; k = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; in_sign = 1'(c); in_exp = bp_e[k]; in_man = bp_m[k]; in_rm = 2'd0;
      in_sign = 0;
      #1;
      check_eq("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
      tick();
      if (last_acc) k++;
    end
    check_eq("bp_accepted", k, 2);
    out_ready = 1; drained = 0; n = 0;
    while (drained < 5 && n < 20) begin
      in_valid = (k < 5);
      if (k < 5) begin in_exp = bp_e[k]; in_man = bp_m[k]; end
      tick();
      if (last_acc) k++;
      n++;
    end
    in_valid = 0;
    check_eq("bp_drain_cycles", n, 5);
    check_eq("bp_drained", drained, 5);

    // Asynchronous reset with two beats in flight
    lat_chk = 1;
    send(0, 8'h10, 28'h1234567, 2'd0);
    send(1, 8'h20, 28'h89ABCDE, 2'd2);
    check_eq("pre_rst_valid", out_valid, 1);
    rst = 1;
    #1;
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_outputs", {out_sign, out_exp, out_frac, out_inexact, out_overflow}, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    q.delete(); prev_stall = 0;
    @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    drained = 0;
    send(0, 8'h42, 28'h9876543, 2'd1);
    for (int i = 0; i < 6; i++) tick();
    check_eq("post_rst_drained", drained, 1);
    check_eq("post_rst_queue", q.size(), 0);
    lat_chk = 0;

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_sign   = 1'($urandom);
      in_rm     = 2'($urandom);
      case ($urandom % 8)
        0:       in_exp = '0;
        1:       in_exp = '1;
        2:       in_exp = 8'hFE;
        3:       in_exp = 8'h01;
        default: in_exp = EXP_W'($urandom);
      endcase
      in_man = MW'($urandom);
      if (($urandom % 4) == 0) in_man[GRS_W-1:0] = 4'h8;
      if (($urandom % 6) == 0) in_man[MW-2:GRS_W] = '1;
      tick();
    end
    in_valid = 0; out_ready = 1;
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
